lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
- Consumer end of the processor's memory-mapped LCD output register.
- Takes the 32-bit LCD word written by software and converts each write request into one correctly timed HD44780-style bus cycle on the LCD pins (RS/RW setup, EN pulse, hold, command gap).
- Sits between the core's LCD output and the board pins.
- Returns busy and read-back data so software polls instead of bit-banging EN.

Parameters:
- T_SETUP, 4, clk cycles RS/RW/DATA stable before EN rises (min 1)
- T_PW, 25, clk cycles EN held high (min 1)
- T_HOLD, 2, clk cycles bus held after EN falls (min 1)
- T_GAP, 2000, clk cycles of command-execution wait after hold (min 1)
- CNT_W, 16, width of the timing down-counter; every T_* must be < 2^CNT_W

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- lcd_word_i  in  32  LCD register word: [31] ON, [11] STROBE toggle, [9] RS, [8] RW, [7:0] DATA
- lcd_data_i  in  8  data pins sampled on read cycles
- lcd_on_o  out  1  LCD power/backlight enable
- lcd_en_o  out  1  LCD enable strobe
- lcd_rs_o  out  1  register select
- lcd_rw_o  out  1  1 = read, 0 = write
- lcd_data_o  out  8  data driven to pins
- lcd_data_oe_o  out  1  1 = drive lcd_data_o onto pins
- busy_o  out  1  transaction in progress (state != IDLE)
- done_o  out  1  one-cycle pulse at end of transaction
- rd_data_o  out  8  last byte read
- drop_o  out  1  sticky: a request was lost

Behaviour:
- Reset (asynchronous, active-low) clears all outputs to 0: EN, RS, RW, DATA, OE, ON, busy, done, rd_data, drop. It also clears strobe_q, the pending flag and the counter, and sets state = IDLE.
- Reset asserted mid-transaction aborts the transaction immediately. EN drops asynchronously and no done_o pulse is produced.
- lcd_on_o = lcd_word_i[31] registered, 1-cycle latency. It is independent of the FSM.
- Request detection: a request occurs in cycle N when lcd_word_i[11] != strobe_q. strobe_q <= lcd_word_i[11] every cycle.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. On each state entry the counter loads T_x-1; the state exits when the counter reaches 0.
- IDLE + request in cycle N:
  - Capture RS/RW/DATA from the same cycle.
  - Go to SETUP at N+1.
  - RS, RW, DATA and OE = ~RW are valid from N+1.
- SETUP lasts T_SETUP cycles, then PULSE.
- PULSE: EN = 1 for exactly T_PW cycles, starting at N+1+T_SETUP. If RW = 1, rd_data_o <= lcd_data_i is sampled on the last PULSE cycle.
- HOLD: EN = 0 for T_HOLD cycles. RS, RW, DATA and OE are unchanged.
- WAIT: T_GAP cycles. OE = 0. RS and RW keep their values.
  - done_o pulses on the last WAIT cycle.
  - Next state is IDLE, or SETUP directly if a request is pending (no IDLE bubble).
- busy_o = 1 from N+1 through the last WAIT cycle. Transaction length = T_SETUP+T_PW+T_HOLD+T_GAP cycles.
- Request while busy: if no request is pending, capture the word into a one-deep pending buffer. If one is already pending, discard the new request and set drop_o = 1 (sticky until reset).
- Request in the same cycle as the last WAIT cycle: counts as a request while busy. It is buffered and starts next cycle.
- Captured fields are frozen for the whole transaction. Changes to lcd_word_i[9:0] without a STROBE toggle are ignored.
- The counter never wraps. The minimum value 1 for each T_* gives a 1-cycle state.

Test Plan (T_SETUP=2, T_PW=3, T_HOLD=1, T_GAP=5 unless stated):
- Reset with lcd_word_i=0x8000_0A41, release, then hold the word -> reset values as listed above; drop_o=0. After release, lcd_on_o=1 one cycle later and exactly one transaction runs (STROBE=1 vs strobe_q=0).
- Write: toggle STROBE with RS=1, RW=0, DATA=0x48 at cycle N:
  - lcd_rs_o=1, lcd_data_o=0x48, OE=1 from N+1.
  - EN high for cycles N+3..N+5.
  - done_o at N+11; busy_o low at N+12.
- Read: RW=1, lcd_data_i=0x80 during PULSE -> OE=0 throughout and rd_data_o=0x80 after the last PULSE cycle.
- Back-to-back: second toggle at N+4 -> second SETUP starts at N+12 with the second word's fields; drop_o stays 0.
- Overflow: three toggles at N, N+2, N+4 -> the N+2 request runs second, the N+4 request is lost, and drop_o=1 from N+5.
- Abort: assert rst_ni low at N+4 (during PULSE) -> EN=0 and busy_o=0 immediately; no done_o pulse.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// Turns each STROBE toggle of the LCD register word into one timed HD44780 bus cycle
// (setup, EN pulse, hold, command gap) with a one-deep pending buffer behind it.
module lcd_bus_sequencer #(
  parameter int T_SETUP = 4,
  parameter int T_PW    = 25,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 2000,
  parameter int CNT_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_word_i,
  input  logic [7:0]  lcd_data_i,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_data_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rd_data_o,
  output logic        drop_o
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } req_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_ld;
  logic             strobe_q, pend_q, on_q, drop_q;
  req_t             cur_q, pend_req_q, word_req;
  logic [7:0]       rd_q;
  logic             req, last, busy, wait_end;
  logic             unused;

  assign unused   = ^{lcd_word_i[30:12], lcd_word_i[10]};
  assign word_req = {lcd_word_i[9], lcd_word_i[8], lcd_word_i[7:0]};
  assign req      = lcd_word_i[11] ^ strobe_q;
  assign last     = (cnt == '0);
  assign busy     = (state != IDLE);
  assign wait_end = (state == WAIT) && last;

  // State register, counter and captured fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      strobe_q   <= 1'b0;
      on_q       <= 1'b0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      cur_q      <= '0;
      pend_req_q <= '0;
      rd_q       <= '0;
    end else begin
      state    <= state_nxt;
      strobe_q <= lcd_word_i[11];
      on_q     <= lcd_word_i[31];
      if (state_nxt != state) cnt <= cnt_ld;
      else if (!last)         cnt <= cnt - 1'b1;
      if (state == IDLE && req)         cur_q <= word_req;
      else if (wait_end && state_nxt == SETUP)
        cur_q <= pend_q ? pend_req_q : word_req;
      // A request arriving on the last WAIT cycle bypasses the buffer directly into SETUP
      if (wait_end) pend_q <= 1'b0;
      else if (busy && req && !pend_q) begin
        pend_q     <= 1'b1;
        pend_req_q <= word_req;
      end
      if (busy && req && pend_q) drop_q <= 1'b1;
      if (state == PULSE && last && cur_q.rw) rd_q <= lcd_data_i;
    end
  end

  // Next-state and counter reload
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req)  state_nxt = SETUP;
      SETUP:   if (last) state_nxt = PULSE;
      PULSE:   if (last) state_nxt = HOLD;
      HOLD:    if (last) state_nxt = WAIT;
      WAIT:    if (last) state_nxt = (pend_q || req) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
    cnt_ld = '0;
    unique case (state_nxt)
      SETUP:   cnt_ld = CNT_W'(T_SETUP - 1);
      PULSE:   cnt_ld = CNT_W'(T_PW - 1);
      HOLD:    cnt_ld = CNT_W'(T_HOLD - 1);
      WAIT:    cnt_ld = CNT_W'(T_GAP - 1);
      default: cnt_ld = '0;
    endcase
  end

  // Outputs decoded from state so a reset drops EN at once
  always_comb begin
    lcd_on_o      = on_q;
    lcd_en_o      = (state == PULSE);
    lcd_rs_o      = cur_q.rs;
    lcd_rw_o      = cur_q.rw;
    lcd_data_o    = cur_q.data;
    lcd_data_oe_o = ~cur_q.rw && (state == SETUP || state == PULSE || state == HOLD);
    busy_o        = busy;
    done_o        = wait_end;
    rd_data_o     = rd_q;
    drop_o        = drop_q;
  end
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboarded bench: requests are scheduled by an arithmetic model, a negedge monitor checks pins.
module tb_lcd_bus_sequencer;
  localparam int TS = 2, TP = 3, TH = 1, TG = 5;
  localparam int L  = TS + TP + TH + TG;

  typedef struct {
    int         start;
    int         fin;
    bit         rs;
    bit         rw;
    bit [7:0]   data;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] word = 32'h0;
  logic [7:0]  lcd_data = 8'h0;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_oe, busy, done, drop;
  logic [7:0]  lcd_dout, rd_data;

  int   cyc = 0, total = 0, bad = 0;
  txn_t q[$];
  int   last_start = -1, last_end = -1, drop_cyc = -1;
  bit   prev_stb = 1'b0, on_exp = 1'b0, run = 1'b0;
  bit [7:0] last_rd = 8'h0;

  lcd_bus_sequencer #(.T_SETUP(TS), .T_PW(TP), .T_HOLD(TH), .T_GAP(TG), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lcd_word_i(word), .lcd_data_i(lcd_data),
    .lcd_on_o(lcd_on), .lcd_en_o(lcd_en), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
    .lcd_data_o(lcd_dout), .lcd_data_oe_o(lcd_oe), .busy_o(busy), .done_o(done),
    .rd_data_o(rd_data), .drop_o(drop)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [7:0] dat_at(input int c);
    return 8'((c * 37) ^ 32'h5a);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", n, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_start = -1; last_end = -1; drop_cyc = -1;
    prev_stb = 1'b0; last_rd = 8'h0;
  endtask

  // A request at cycle n starts at once if idle, queues behind the running one
  // if nothing is waiting, otherwise is lost.
  task automatic request(input logic [31:0] w);
    int n, s;
    txn_t t;
    n = cyc;
    if (n > last_end) s = n + 1;
    else if (last_start > n) begin
      if (drop_cyc < 0) drop_cyc = n + 1;
      return;
    end else s = last_end + 1;
    t.start = s; t.fin = s + L - 1; t.rs = w[9]; t.rw = w[8]; t.data = w[7:0];
    q.push_back(t);
    last_start = s; last_end = t.fin;
  endtask

  task automatic tick(input logic [31:0] w, input logic r);
    logic was;
    @(posedge clk_i); #1;
    was = rst_ni;
    on_exp = r & rst_ni & word[31];
    word = w; rst_ni = r; lcd_data = dat_at(cyc);
    if (!r) begin
      model_reset();
      if (was) begin
        #1;
        chk("abort_en", lcd_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
      end
    end else begin
      if (w[11] != prev_stb) request(w);
      prev_stb = w[11];
    end
  endtask

  function automatic logic [31:0] tog(input bit rs, input bit rw, input logic [7:0] d);
    logic [31:0] w;
    w = word; w[11] = ~w[11]; w[9] = rs; w[8] = rw; w[7:0] = d;
    return w;
  endfunction

  always @(negedge clk_i) begin
    if (run) begin
      if (!rst_ni) begin
        chk("rst_en", lcd_en, 0);   chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);   chk("rst_data", lcd_dout, 0);
        chk("rst_oe", lcd_oe, 0);   chk("rst_on", lcd_on, 0);
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_rd", rd_data, 0);  chk("rst_drop", drop, 0);
      end else begin
        chk("on", lcd_on, on_exp);
        chk("drop", drop, (drop_cyc >= 0 && cyc >= drop_cyc) ? 1 : 0);
        if (q.size() > 0 && cyc >= q[0].start) begin
          txn_t t;
          int p0;
          bit [7:0] er;
          t = q[0]; p0 = t.start + TS;
          chk("busy", busy, 1);
          chk("en", lcd_en, (cyc >= p0 && cyc < p0 + TP) ? 1 : 0);
          chk("oe", lcd_oe, (!t.rw && cyc < p0 + TP + TH) ? 1 : 0);
          chk("rs", lcd_rs, t.rs);
          chk("rw", lcd_rw, t.rw);
          if (cyc < p0 + TP + TH) chk("data", lcd_dout, t.data);
          chk("done", done, (cyc == t.fin) ? 1 : 0);
          if (done || cyc == t.fin) begin
            chk("done_cyc", cyc, t.fin);
            er = t.rw ? dat_at(p0 + TP - 1) : last_rd;
            chk("rd_data", rd_data, er);
            last_rd = er;
            void'(q.pop_front());
          end
        end else begin
          chk("idle_busy", busy, 0);
          chk("idle_en", lcd_en, 0);
          chk("idle_oe", lcd_oe, 0);
          chk("idle_done", done, 0);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    word = 32'h8000_0A41;
    #2 rst_ni = 1'b0;
    model_reset();
    run = 1'b1;
    repeat (3) tick(word, 1'b0);
    repeat (16) tick(word, 1'b1);                 // power-up request runs once
    tick(tog(1, 0, 8'h48), 1'b1);                 // write
    repeat (14) tick(word, 1'b1);
    tick(tog(0, 1, 8'h00), 1'b1);                 // read
    repeat (14) tick(word, 1'b1);
    w = word; w[9:0] = 10'h3ff; tick(w, 1'b1);    // field change without toggle is ignored
    repeat (3) tick(word, 1'b1);
    tick(tog(1, 0, 8'h11), 1'b1);                 // back-to-back
    repeat (3) tick(word, 1'b1);
    tick(tog(0, 0, 8'h22), 1'b1);
    repeat (25) tick(word, 1'b1);
    tick(tog(1, 0, 8'h31), 1'b1);                 // overflow: third request lost
    tick(word, 1'b1);
    tick(tog(1, 1, 8'h32), 1'b1);
    tick(word, 1'b1);
    tick(tog(0, 0, 8'h33), 1'b1);
    repeat (30) tick(word, 1'b1);
    tick(tog(1, 0, 8'h55), 1'b1);                 // abort during PULSE
    repeat (3) tick(word, 1'b1);
    tick(word, 1'b0);
    tick(word, 1'b0);
    w = word; w[11] = 1'b0; tick(w, 1'b1);
    repeat (5) tick(word, 1'b1);
    for (int i = 0; i < 600; i++) begin
      w = word;
      if ($urandom_range(0, 9) == 0) begin
        w[11] = ~w[11]; w[9:0] = 10'($urandom);
      end else if ($urandom_range(0, 3) == 0) w[9:0] = 10'($urandom);
      if ($urandom_range(0, 30) == 0) w[31] = ~w[31];
      if (i == 300) begin
        tick(w, 1'b0); tick(w, 1'b0);
      end
      tick(w, 1'b1);
    end
    repeat (30) tick(word, 1'b1);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
